// File: rtl/fifo_txuart.sv
// fifo_txuart: drains ufifo bytes as 8N1 UART frames, with CTS flow control and line break.
// Revision 1.0
`default_nettype none

module fifo_txuart #(
  parameter logic [23:0] CLOCKS_PER_BAUD = 24'd868
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_empty_n,
  input  logic [7:0] i_data,
  output logic       o_rd,
  input  logic       i_cts_n,
  input  logic       i_break,
  output logic       o_uart_tx,
  output logic       o_busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  localparam logic [23:0] C_BAUD_RELOAD = CLOCKS_PER_BAUD - 24'd1;

  state_t      state_q, state_d;
  logic [23:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        baud_done_w;

  assign baud_done_w = (baud_q == 24'd0);

  // Pop is suppressed during reset so an abandoned frame never costs a byte.
  assign o_rd      = ~i_rst & (state_q == S_IDLE) & i_empty_n & ~i_cts_n & ~i_break;
  assign o_busy    = (state_q != S_IDLE);
  assign o_uart_tx = tx_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      baud_q  <= 24'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (i_break) begin
          state_d = S_BREAK;
          tx_d    = 1'b0;
          baud_d  = C_BAUD_RELOAD;
        end else if (o_rd) begin
          state_d = S_START;
          shift_d = i_data;
          bit_d   = 3'd0;
          tx_d    = 1'b0;
          baud_d  = C_BAUD_RELOAD;
        end
      end

      S_START: begin
        if (baud_done_w) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
          baud_d  = C_BAUD_RELOAD;
        end else begin
          baud_d = baud_q - 24'd1;
        end
      end

      S_DATA: begin
        if (baud_done_w) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          baud_d  = C_BAUD_RELOAD;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d = shift_q[1];
          end
        end else begin
          baud_d = baud_q - 24'd1;
        end
      end

      S_STOP: begin
        if (baud_done_w) begin
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q - 24'd1;
        end
      end

      S_BREAK: begin
        // tx_q doubles as the "in mark recovery" flag: low while breaking, high while recovering.
        if (i_break) begin
          tx_d   = 1'b0;
          baud_d = C_BAUD_RELOAD;
        end else if (!tx_q) begin
          tx_d   = 1'b1;
          baud_d = C_BAUD_RELOAD;
        end else if (baud_done_w) begin
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q - 24'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        baud_d  = 24'd0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_txuart.sv
// tb_fifo_txuart: directed bench for fifo_txuart with CLOCKS_PER_BAUD=4 and a small FIFO model.
// Revision 1.0
`default_nettype none

module tb_fifo_txuart;

  localparam logic [23:0] CPB = 24'd4;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_empty_n;
  logic [7:0] i_data;
  logic       o_rd;
  logic       i_cts_n;
  logic       i_break;
  logic       o_uart_tx;
  logic       o_busy;

  always #5 i_clk = ~i_clk;

  fifo_txuart #(.CLOCKS_PER_BAUD(CPB)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_empty_n(i_empty_n),
    .i_data   (i_data),
    .o_rd     (o_rd),
    .i_cts_n  (i_cts_n),
    .i_break  (i_break),
    .o_uart_tx(o_uart_tx),
    .o_busy   (o_busy)
  );

  logic [7:0] fifo_mem [0:15];
  logic [3:0] head = 4'd0;
  logic [3:0] tail = 4'd0;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int pops        = 0;
  logic s_tx, s_rd, s_busy;

  task automatic push(input logic [7:0] b);
    fifo_mem[tail] = b;
    tail           = tail + 4'd1;
    i_empty_n      = 1'b1;
    i_data         = fifo_mem[head];
  endtask

  // One clock: sample mid-cycle, apply the FIFO pop, present the new head after the edge.
  task automatic cycle();
    @(negedge i_clk);
    s_tx   = o_uart_tx;
    s_rd   = o_rd;
    s_busy = o_busy;
    cyc++;
    if (s_rd) begin
      pops++;
      head = head + 4'd1;
    end
    @(posedge i_clk);
    #1;
    i_empty_n = (head != tail);
    i_data    = fifo_mem[head];
  endtask

  task automatic wait_rd(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      cycle();
      if (s_rd) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic capture(output logic [39:0] txv, output logic [39:0] bzv, output int rdc);
    rdc = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      txv[i] = s_tx;
      bzv[i] = s_busy;
      if (s_rd) rdc++;
    end
  endtask

  function automatic logic [39:0] frame_exp(input logic [7:0] b);
    logic [39:0] v;
    for (int i = 0; i < 40; i++) begin
      int idx;
      idx = i / 4;
      if (idx == 0)      v[i] = 1'b0;
      else if (idx == 9) v[i] = 1'b1;
      else               v[i] = b[idx-1];
    end
    return v;
  endfunction

  task automatic test_reset();
    int bad;
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    vectors++;
    if ({o_uart_tx, o_busy, o_rd} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_state: tx/busy/rd=%b want 100", {o_uart_tx, o_busy, o_rd});
    end
    i_rst = 1'b0;
    bad   = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if ({s_tx, s_rd, s_busy} !== 3'b100) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL idle_quiet: %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_single();
    bit ok;
    logic [39:0] txv, bzv;
    int rdc, p0;
    p0 = pops;
    push(8'h55);
    wait_rd(5, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL single_rd: no pop seen want pop");
    end
    capture(txv, bzv, rdc);
    vectors++;
    if (txv !== 40'hF0F0F0F0F0) begin
      miscompares++;
      $display("FAIL single_frame: got %h want %h", txv, 40'hF0F0F0F0F0);
    end
    vectors++;
    if (bzv !== 40'hFFFFFFFFFF) begin
      miscompares++;
      $display("FAIL single_busy: got %h want %h", bzv, 40'hFFFFFFFFFF);
    end
    cycle();
    vectors++;
    if ({s_tx, s_busy, s_rd} !== 3'b100 || pops - p0 != 1 || rdc != 0) begin
      miscompares++;
      $display("FAIL single_end: tx/busy/rd=%b pops=%0d want 100 pops=1", {s_tx, s_busy, s_rd}, pops - p0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [4];
    bit ok;
    logic [39:0] txv, bzv;
    int rdc, t_prev, p0;
    bytes[0] = 8'hA3; bytes[1] = 8'h00; bytes[2] = 8'hFF; bytes[3] = 8'h81;
    p0     = pops;
    t_prev = 0;
    for (int f = 0; f < 4; f++) push(bytes[f]);
    for (int f = 0; f < 4; f++) begin
      wait_rd((f == 0) ? 5 : 60, ok);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL b2b_rd%0d: no pop want pop", f);
      end
      if (f > 0) begin
        vectors++;
        if (cyc - t_prev != 41) begin
          miscompares++;
          $display("FAIL b2b_gap%0d: got %0d want 41", f, cyc - t_prev);
        end
      end
      t_prev = cyc;
      capture(txv, bzv, rdc);
      vectors++;
      if (txv !== frame_exp(bytes[f])) begin
        miscompares++;
        $display("FAIL b2b_frame%0d: got %h want %h", f, txv, frame_exp(bytes[f]));
      end
    end
    vectors++;
    if (pops - p0 != 4) begin
      miscompares++;
      $display("FAIL b2b_pops: got %0d want 4", pops - p0);
    end
  endtask

  task automatic test_cts();
    bit ok;
    logic [39:0] txv, bzv;
    int rdc, bad;
    i_cts_n = 1'b1;
    push(8'hA5);
    push(8'h3C);
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      cycle();
      if (s_rd || !s_tx || s_busy) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL cts_hold: %0d active cycles want 0", bad);
    end
    i_cts_n = 1'b0;
    cycle();
    vectors++;
    if (s_rd !== 1'b1 || s_tx !== 1'b1) begin
      miscompares++;
      $display("FAIL cts_release: rd=%b tx=%b want rd=1 tx=1", s_rd, s_tx);
    end
    i_cts_n = 1'b1;
    capture(txv, bzv, rdc);
    vectors++;
    if (txv !== frame_exp(8'hA5) || rdc != 0) begin
      miscompares++;
      $display("FAIL cts_midframe: got %h want %h", txv, frame_exp(8'hA5));
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (s_rd || !s_tx || s_busy) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL cts_after: %0d active cycles want 0", bad);
    end
    i_cts_n = 1'b0;
    wait_rd(3, ok);
    capture(txv, bzv, rdc);
    vectors++;
    if (!ok || txv !== frame_exp(8'h3C)) begin
      miscompares++;
      $display("FAIL cts_second: ok=%b got %h want %h", ok, txv, frame_exp(8'h3C));
    end
  endtask

  task automatic test_break();
    logic [34:0] txv, bzv, rdv;
    logic [15:0] brk, t16, b16;
    logic [39:0] ftx, fbz;
    int rdc;
    i_break = 1'b1;
    push(8'h96);
    rdv = '0;
    for (int i = 0; i < 35; i++) begin
      if (i == 30) i_break = 1'b0;
      cycle();
      txv[i] = s_tx;
      bzv[i] = s_busy;
      rdv[i] = s_rd;
    end
    vectors++;
    if (txv !== 35'h780000001) begin
      miscompares++;
      $display("FAIL break_tx: got %h want %h", txv, 35'h780000001);
    end
    vectors++;
    if (bzv !== 35'h7FFFFFFFE || rdv !== 35'h0) begin
      miscompares++;
      $display("FAIL break_busy_rd: busy=%h rd=%h want busy=7fffffffe rd=0", bzv, rdv);
    end
    cycle();
    vectors++;
    if (s_rd !== 1'b1 || s_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL break_then_rd: rd=%b busy=%b want rd=1 busy=0", s_rd, s_busy);
    end
    capture(ftx, fbz, rdc);
    vectors++;
    if (ftx !== frame_exp(8'h96)) begin
      miscompares++;
      $display("FAIL break_frame: got %h want %h", ftx, frame_exp(8'h96));
    end
    // Re-break during mark recovery restarts the recovery count.
    brk = 16'h039F;
    for (int i = 0; i < 16; i++) begin
      i_break = brk[i];
      cycle();
      t16[i] = s_tx;
      b16[i] = s_busy;
    end
    i_break = 1'b0;
    vectors++;
    if (t16 !== 16'hF8C1 || b16 !== 16'h7FFE) begin
      miscompares++;
      $display("FAIL rebreak: tx=%h busy=%h want tx=f8c1 busy=7ffe", t16, b16);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    logic [39:0] txv, bzv;
    int rdc, p0;
    push(8'hC3);
    push(8'h5A);
    wait_rd(5, ok);
    p0 = pops;
    repeat (12) cycle();
    #2;
    i_rst = 1'b1;
    #1;
    vectors++;
    if (o_uart_tx !== 1'b1 || o_busy !== 1'b0 || o_rd !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: tx=%b busy=%b rd=%b want 1 0 0", o_uart_tx, o_busy, o_rd);
    end
    cycle();
    cycle();
    i_rst = 1'b0;
    vectors++;
    if (!ok || pops != p0) begin
      miscompares++;
      $display("FAIL reset_pops: ok=%b pops=%0d want %0d", ok, pops, p0);
    end
    wait_rd(3, ok);
    capture(txv, bzv, rdc);
    vectors++;
    if (!ok || txv !== frame_exp(8'h5A) || pops != p0 + 1) begin
      miscompares++;
      $display("FAIL post_reset_frame: ok=%b got %h want %h pops=%0d want %0d",
               ok, txv, frame_exp(8'h5A), pops, p0 + 1);
    end
    cycle();
    vectors++;
    if ({s_tx, s_busy, s_rd} !== 3'b100) begin
      miscompares++;
      $display("FAIL post_reset_idle: tx/busy/rd=%b want 100", {s_tx, s_busy, s_rd});
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    i_rst     = 1'b1;
    i_empty_n = 1'b0;
    i_data    = 8'h00;
    i_cts_n   = 1'b0;
    i_break   = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_cts();
    test_break();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
